layer_controller: RTL

Sequences one layer of neuron instances that share a common input vector. It accepts an input vector through a valid/ready handshake and holds it stable on the shared neuron input bus. It issues one start pulse to all neurons, collects each neuron's one-cycle done pulse and result, and presents the completed output vector downstream through a valid/ready handshake. A watchdog aborts a compute that stalls.

---
 rtl/layer_controller_pkg.sv | 29 ++
 rtl/layer_watchdog.sv | 31 +++
 rtl/layer_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/layer_controller_pkg.sv
// Shared types for the layer controller: fixed-point format, activation kinds and FSM states.
package layer_controller_pkg;

  localparam int INTEGRAL_WIDTH = 8;
  localparam int FRACTION_WIDTH = 8;
  localparam int FIXED_WIDTH    = INTEGRAL_WIDTH + FRACTION_WIDTH;

  typedef logic signed [FIXED_WIDTH-1:0] fixed_point;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RELU,
    ACT_SIGMOID,
    ACT_TANH
  } activation_type;

  typedef enum logic [1:0] {
    IDLE,
    START,
    COMPUTE,
    HOLD
  } layer_state;

  // Bits needed to hold every value from 0 up to and including maxValue.
  function automatic int count_width(input int maxValue);
    return $clog2(maxValue + 1);
  endfunction

endpackage

// File: rtl/layer_watchdog.sv
// Saturating cycle counter; o_expired flags the enabled cycle on which the count reaches LIMIT.
module layer_watchdog
  import layer_controller_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = count_width(LIMIT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expires on the cycle whose increment would bring the count to LIMIT.
  assign o_expired = i_enable && (r_count >= CW'(LIMIT - 1));

endmodule

// File: rtl/layer_controller.sv
// Sequences one neuron layer: accept a vector, pulse start, gather per-neuron results, hand off downstream.
module layer_controller
  import layer_controller_pkg::*;
#(
  parameter int NUM_INPUTS     = 16,
  parameter int NUM_NEURONS    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  fixed_point [NUM_INPUTS-1:0]   in_data,
  output fixed_point [NUM_INPUTS-1:0]   neuron_inputs,
  output logic                          neuron_start,
  input  logic [NUM_NEURONS-1:0]        neuron_done,
  input  fixed_point [NUM_NEURONS-1:0]  neuron_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output fixed_point [NUM_NEURONS-1:0]  out_data,
  output logic                          busy,
  output logic                          error,
  input  logic                          clear_error
);

  if (NUM_NEURONS < 1) begin : g_badNeurons
    $fatal(1, "layer_controller: NUM_NEURONS must be at least 1");
  end
  if (TIMEOUT_CYCLES < NUM_INPUTS + 4) begin : g_badTimeout
    $fatal(1, "layer_controller: TIMEOUT_CYCLES must be at least NUM_INPUTS+4");
  end

  layer_state                   r_state;
  layer_state                   w_nextState;
  fixed_point [NUM_INPUTS-1:0]  r_neuronInputs;
  fixed_point [NUM_NEURONS-1:0] r_outData;
  logic [NUM_NEURONS-1:0]       r_doneMask;
  logic                         r_error;

  logic                         w_accept;
  logic                         w_expired;
  logic                         w_allDone;
  logic                         w_timeout;
  logic [NUM_NEURONS-1:0]       w_newDone;
  logic [NUM_NEURONS-1:0]       w_maskNext;

  // Only first pulses seen during COMPUTE count; everything else is dropped here.
  assign w_newDone  = (r_state == COMPUTE) ? (neuron_done & ~r_doneMask) : '0;
  assign w_maskNext = r_doneMask | w_newDone;
  assign w_allDone  = &w_maskNext;
  assign w_accept   = in_valid && in_ready;
  assign w_timeout  = (r_state == COMPUTE) && !w_allDone && w_expired;

  layer_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_enable  (r_state == COMPUTE),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = START;
      START:   w_nextState = COMPUTE;
      COMPUTE: begin
        if (w_allDone) begin
          w_nextState = HOLD;
        end else if (w_expired) begin
          w_nextState = IDLE;
        end
      end
      HOLD:    if (out_ready) w_nextState = in_valid ? START : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Completion wins over an expiry landing on the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_neuronInputs <= '0;
      r_outData      <= '0;
      r_doneMask     <= '0;
      r_error        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_neuronInputs <= in_data;
        r_doneMask     <= '0;
      end else begin
        r_doneMask <= w_maskNext;
      end
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_newDone[i]) begin
          r_outData[i] <= neuron_out[i];
        end
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end else if (clear_error) begin
        r_error <= 1'b0;
      end
    end
  end

  assign in_ready      = reset && ((r_state == IDLE) || ((r_state == HOLD) && out_ready));
  assign neuron_start  = (r_state == START);
  assign out_valid     = (r_state == HOLD);
  assign busy          = (r_state != IDLE);
  assign error         = r_error;
  assign neuron_inputs = r_neuronInputs;
  assign out_data      = r_outData;

endmodule
